// File: rtl/sdn_parser_pkg.sv
// Shared types and sizing for the parser/deparser datapath: word and field widths,
// the deparser state encoding and the fill-counter width.
package sdn_parser_pkg;

    localparam int PRS_DATA_W       = 512;
    localparam int PRS_OFFSET_W     = 32;
    localparam int DEP_FIELD_W      = 128;
    localparam int HEAD_FIELD_LEN_W = 9;

    function automatic int clog2(input int value);
        int result;
        int rest;
        result = 0;
        rest   = value - 1;
        while (rest > 0) begin
            result = result + 1;
            rest   = rest >> 1;
        end
        return result;
    endfunction

    // Fill plus one field can exceed a word, hence the extra bit.
    localparam int FILL_W = clog2(PRS_DATA_W) + 1;
    localparam int BITS_W = HEAD_FIELD_LEN_W + 1;
    localparam int EXT_W  = PRS_DATA_W + DEP_FIELD_W;

    typedef enum logic {
        PACK  = 1'b0,
        FLUSH = 1'b1
    } dep_state_t;

endpackage

// File: rtl/sdn_deparser_emission_core_if.sv
// Field input stream and packed-word output stream of the deparser emission core.
interface sdn_deparser_emission_core_if;
    import sdn_parser_pkg::*;

    logic [PRS_OFFSET_W-1:0]     dep_start_addr_i;
    logic [DEP_FIELD_W-1:0]      dep_field_data_i;
    logic [HEAD_FIELD_LEN_W-1:0] dep_field_len_i;
    logic                        dep_field_valid_i;
    logic                        dep_field_last_i;
    logic                        dep_field_ready_o;
    logic [PRS_DATA_W-1:0]       dep_data_word_o;
    logic                        dep_data_valid_o;
    logic                        dep_data_ready_i;
    logic                        dep_data_last_o;
    logic [BITS_W-1:0]           dep_data_bits_o;
    logic [PRS_OFFSET_W-1:0]     dep_finish_addr_o;
    logic                        dep_finished_o;
    logic                        dep_hold_en_o;

    modport master (
        output dep_start_addr_i, dep_field_data_i, dep_field_len_i,
               dep_field_valid_i, dep_field_last_i, dep_data_ready_i,
        input  dep_field_ready_o, dep_data_word_o, dep_data_valid_o,
               dep_data_last_o, dep_data_bits_o, dep_finish_addr_o,
               dep_finished_o, dep_hold_en_o
    );

    modport slave (
        input  dep_start_addr_i, dep_field_data_i, dep_field_len_i,
               dep_field_valid_i, dep_field_last_i, dep_data_ready_i,
        output dep_field_ready_o, dep_data_word_o, dep_data_valid_o,
               dep_data_last_o, dep_data_bits_o, dep_finish_addr_o,
               dep_finished_o, dep_hold_en_o
    );

endinterface

// File: rtl/sdn_deparser_bit_packer.sv
// Combinational barrel shift and merge of one right-aligned field into the MSB-first
// accumulator; reports a completed word and the carried-over remainder.
module sdn_deparser_bit_packer
    import sdn_parser_pkg::*;
(
    input  logic [PRS_DATA_W-1:0]       acc,
    input  logic [FILL_W-1:0]           fill,
    input  logic [DEP_FIELD_W-1:0]      field,
    input  logic [HEAD_FIELD_LEN_W-1:0] n,
    output logic [PRS_DATA_W-1:0]       next_acc,
    output logic [PRS_DATA_W-1:0]       word_out,
    output logic                        word_done,
    output logic [FILL_W-1:0]           next_fill
);

    logic [DEP_FIELD_W-1:0] masked;
    logic [FILL_W-1:0]      sum;
    logic [FILL_W-1:0]      rem;
    logic [FILL_W-1:0]      shamt;
    logic [EXT_W-1:0]       placed;
    logic [EXT_W-1:0]       merged;

    // The accumulator is extended by one field width below so that bits spilling
    // past the word boundary land in the low slice and become the remainder.
    assign masked    = field & ~({DEP_FIELD_W{1'b1}} << n);
    assign sum       = fill + FILL_W'(n);
    assign shamt     = FILL_W'(EXT_W) - sum;
    assign placed    = {{PRS_DATA_W{1'b0}}, masked} << shamt;
    assign merged    = {acc, {DEP_FIELD_W{1'b0}}} | placed;
    assign word_done = (sum >= FILL_W'(PRS_DATA_W));
    assign rem       = sum - FILL_W'(PRS_DATA_W);

    assign word_out  = merged[EXT_W-1 -: PRS_DATA_W];
    assign next_acc  = word_done ? {merged[DEP_FIELD_W-1:0], {(PRS_DATA_W-DEP_FIELD_W){1'b0}}}
                                 : merged[EXT_W-1 -: PRS_DATA_W];
    assign next_fill = word_done ? rem : sum;

endmodule

// File: rtl/sdn_deparser_emission_core.sv
// Deparser emission core: packs header fields MSB-first into packet words, emits them
// on a valid/ready stream and reports the header finish address.
module sdn_deparser_emission_core
    import sdn_parser_pkg::*;
(
    input  logic                       clk,
    input  logic                       resetn,
    sdn_deparser_emission_core_if.slave bus
);

    dep_state_t state_q, state_d;

    logic [PRS_DATA_W-1:0]       acc_q;
    logic [FILL_W-1:0]           fill_q;
    logic [PRS_OFFSET_W-1:0]     tot_q;
    logic [PRS_OFFSET_W-1:0]     hdr_start_q;
    logic                        in_hdr_q;
    logic [PRS_DATA_W-1:0]       word_q;
    logic [BITS_W-1:0]           bits_q;
    logic                        valid_q;
    logic                        last_q;
    logic [PRS_OFFSET_W-1:0]     pend_addr_q;
    logic [PRS_OFFSET_W-1:0]     finish_addr_q;
    logic                        finished_q;
    logic                        defer_q;
    logic [PRS_OFFSET_W-1:0]     defer_addr_q;

    logic                        field_ready;
    logic                        accept;
    logic                        out_fire;
    logic                        last_hs;
    logic                        zero_done;
    logic [HEAD_FIELD_LEN_W-1:0] field_n;
    logic [PRS_DATA_W-1:0]       pk_next_acc;
    logic [PRS_DATA_W-1:0]       pk_word;
    logic                        pk_done;
    logic [FILL_W-1:0]           pk_next_fill;
    logic [PRS_OFFSET_W-1:0]     tot_next;
    logic [PRS_OFFSET_W-1:0]     start_eff;
    logic [PRS_OFFSET_W-1:0]     done_addr;

    assign field_n = (bus.dep_field_len_i > HEAD_FIELD_LEN_W'(DEP_FIELD_W))
                   ? HEAD_FIELD_LEN_W'(DEP_FIELD_W) : bus.dep_field_len_i;

    sdn_deparser_bit_packer u_packer (
        .acc       (acc_q),
        .fill      (fill_q),
        .field     (bus.dep_field_data_i),
        .n         (field_n),
        .next_acc  (pk_next_acc),
        .word_out  (pk_word),
        .word_done (pk_done),
        .next_fill (pk_next_fill)
    );

    assign out_fire  = valid_q && bus.dep_data_ready_i;
    assign last_hs   = out_fire && last_q;
    assign accept    = field_ready && bus.dep_field_valid_i;
    assign tot_next  = tot_q + PRS_OFFSET_W'(field_n);
    assign start_eff = in_hdr_q ? hdr_start_q : bus.dep_start_addr_i;
    assign done_addr = start_eff + tot_next;
    assign zero_done = accept && bus.dep_field_last_i && !pk_done && (pk_next_fill == '0);

    always_comb begin
        state_d     = state_q;
        field_ready = 1'b0;
        case (state_q)
            PACK: begin
                field_ready = !valid_q || bus.dep_data_ready_i;
                if (field_ready && bus.dep_field_valid_i && bus.dep_field_last_i &&
                    pk_done && (pk_next_fill != '0))
                    state_d = FLUSH;
            end
            FLUSH: begin
                if (out_fire)
                    state_d = PACK;
            end
            default: state_d = PACK;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q       <= PACK;
            acc_q         <= '0;
            fill_q        <= '0;
            tot_q         <= '0;
            hdr_start_q   <= '0;
            in_hdr_q      <= 1'b0;
            word_q        <= '0;
            bits_q        <= '0;
            valid_q       <= 1'b0;
            last_q        <= 1'b0;
            pend_addr_q   <= '0;
            finish_addr_q <= '0;
            finished_q    <= 1'b0;
            defer_q       <= 1'b0;
            defer_addr_q  <= '0;
        end else begin
            state_q <= state_d;
            if (out_fire)
                valid_q <= 1'b0;

            if ((state_q == FLUSH) && out_fire) begin
                word_q  <= acc_q;
                bits_q  <= BITS_W'(fill_q);
                last_q  <= 1'b1;
                valid_q <= 1'b1;
                acc_q   <= '0;
                fill_q  <= '0;
            end

            if (accept) begin
                acc_q  <= pk_next_acc;
                fill_q <= pk_next_fill;
                if (bus.dep_field_last_i) begin
                    tot_q       <= '0;
                    in_hdr_q    <= 1'b0;
                    pend_addr_q <= done_addr;
                end else begin
                    tot_q       <= tot_next;
                    in_hdr_q    <= 1'b1;
                    hdr_start_q <= start_eff;
                end
                if (pk_done) begin
                    word_q  <= pk_word;
                    bits_q  <= BITS_W'(PRS_DATA_W);
                    last_q  <= bus.dep_field_last_i && (pk_next_fill == '0);
                    valid_q <= 1'b1;
                end else if (bus.dep_field_last_i) begin
                    acc_q  <= '0;
                    fill_q <= '0;
                    if (pk_next_fill != '0) begin
                        word_q  <= pk_next_acc;
                        bits_q  <= BITS_W'(pk_next_fill);
                        last_q  <= 1'b1;
                        valid_q <= 1'b1;
                    end
                end
            end

            // A word-less header can finish in the same cycle as the previous header's
            // last handshake; the younger completion is then reported one cycle later.
            finished_q <= 1'b0;
            if (defer_q) begin
                finished_q    <= 1'b1;
                finish_addr_q <= defer_addr_q;
                defer_q       <= zero_done;
                defer_addr_q  <= done_addr;
            end else if (last_hs) begin
                finished_q    <= 1'b1;
                finish_addr_q <= pend_addr_q;
                defer_q       <= zero_done;
                defer_addr_q  <= done_addr;
            end else if (zero_done) begin
                finished_q    <= 1'b1;
                finish_addr_q <= done_addr;
            end
        end
    end

    assign bus.dep_field_ready_o = field_ready;
    assign bus.dep_hold_en_o     = !field_ready;
    assign bus.dep_data_word_o   = word_q;
    assign bus.dep_data_valid_o  = valid_q;
    assign bus.dep_data_last_o   = last_q;
    assign bus.dep_data_bits_o   = bits_q;
    assign bus.dep_finish_addr_o = finish_addr_q;
    assign bus.dep_finished_o    = finished_q;

endmodule

// File: tb/tb_sdn_deparser_emission_core.sv
// Randomized bench for the deparser emission core; expected words come from a bit-queue
// model of the header stream and are matched by a negedge scoreboard.
module tb_sdn_deparser_emission_core;
    import sdn_parser_pkg::*;

    typedef struct {
        logic [DEP_FIELD_W-1:0]  data;
        int                      len;
        bit                      last;
        logic [PRS_OFFSET_W-1:0] start;
    } fld_t;

    logic clk    = 1'b0;
    logic resetn = 1'b0;
    int   tests_run    = 0;
    int   tests_failed = 0;
    int   cyc = 0;

    sdn_deparser_emission_core_if bus();

    sdn_deparser_emission_core dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    fld_t hdr[$];
    fld_t fq[$];
    logic [PRS_DATA_W-1:0]   exp_word[$];
    int                      exp_bits[$];
    bit                      exp_last[$];
    logic [PRS_OFFSET_W-1:0] exp_fin[$];

    int n_words = 0;
    int n_fin   = 0;
    int hs_cyc  = 0;
    int fin_cyc = 0;
    int obs_bits = 0;
    bit obs_last = 1'b0;
    logic [PRS_OFFSET_W-1:0] obs_fin = '0;
    logic [PRS_DATA_W-1:0]   mon_w;
    int                      mon_b;
    bit                      mon_l;
    logic [PRS_OFFSET_W-1:0] mon_f;

    // Scoreboard: a handshake seen at the negedge completes on the following posedge.
    always @(negedge clk) begin
        if (resetn) begin
            if (bus.dep_data_valid_o && bus.dep_data_ready_i) begin
                n_words++;
                hs_cyc   = cyc;
                obs_bits = int'(bus.dep_data_bits_o);
                obs_last = bus.dep_data_last_o;
                tests_run++;
                if (exp_word.size() == 0) begin
                    tests_failed++;
                    $display("[TB] FAIL word_unexpected: got bits=%0d last=%0b, required no word",
                             bus.dep_data_bits_o, bus.dep_data_last_o);
                end else begin
                    mon_w = exp_word.pop_front();
                    mon_b = exp_bits.pop_front();
                    mon_l = exp_last.pop_front();
                    if (bus.dep_data_word_o !== mon_w || bus.dep_data_bits_o !== BITS_W'(mon_b) ||
                        bus.dep_data_last_o !== mon_l) begin
                        tests_failed++;
                        $display("[TB] FAIL word_check: got word=%h bits=%0d last=%0b, required word=%h bits=%0d last=%0b",
                                 bus.dep_data_word_o, bus.dep_data_bits_o, bus.dep_data_last_o, mon_w, mon_b, mon_l);
                    end
                end
            end
            if (bus.dep_finished_o) begin
                n_fin++;
                fin_cyc = cyc;
                obs_fin = bus.dep_finish_addr_o;
                tests_run++;
                if (exp_fin.size() == 0) begin
                    tests_failed++;
                    $display("[TB] FAIL finish_unexpected: got addr=%h, required no pulse", bus.dep_finish_addr_o);
                end else begin
                    mon_f = exp_fin.pop_front();
                    if (bus.dep_finish_addr_o !== mon_f) begin
                        tests_failed++;
                        $display("[TB] FAIL finish_addr: got %h, required %h", bus.dep_finish_addr_o, mon_f);
                    end
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    function automatic logic [DEP_FIELD_W-1:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic add_field(input logic [DEP_FIELD_W-1:0] d, input int len, input bit last,
                             input logic [PRS_OFFSET_W-1:0] start);
        fld_t f;
        f.data  = d;
        f.len   = len;
        f.last  = last;
        f.start = (hdr.size() == 0) ? start : $urandom;
        hdr.push_back(f);
    endtask

    // Reference model: flatten the header into a bit stream, then cut it into words.
    task automatic commit_header();
        bit bq[$];
        int n;
        int total;
        int b;
        logic [PRS_DATA_W-1:0] w;
        foreach (hdr[k]) begin
            n = (hdr[k].len > DEP_FIELD_W) ? DEP_FIELD_W : hdr[k].len;
            for (int i = n - 1; i >= 0; i--) bq.push_back(hdr[k].data[i]);
        end
        total = bq.size();
        while (bq.size() > 0) begin
            w = '0;
            b = 0;
            while (b < PRS_DATA_W && bq.size() > 0) begin
                w[PRS_DATA_W-1-b] = bq.pop_front();
                b++;
            end
            exp_word.push_back(w);
            exp_bits.push_back(b);
            exp_last.push_back(bq.size() == 0);
        end
        exp_fin.push_back(hdr[0].start + PRS_OFFSET_W'(total));
        foreach (hdr[k]) fq.push_back(hdr[k]);
        hdr.delete();
    endtask

    task automatic drive_fields(input bit gaps);
        fld_t f;
        int waited;
        while (fq.size() > 0) begin
            f = fq.pop_front();
            if (gaps && $urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
            bus.dep_field_data_i  = f.data;
            bus.dep_field_len_i   = f.len[HEAD_FIELD_LEN_W-1:0];
            bus.dep_field_last_i  = f.last;
            bus.dep_start_addr_i  = f.start;
            bus.dep_field_valid_i = 1'b1;
            waited = 0;
            @(negedge clk);
            while (!bus.dep_field_ready_o && waited < 200) begin
                waited++;
                @(negedge clk);
            end
            tests_run++;
            if (bus.dep_field_ready_o !== 1'b1) begin
                tests_failed++;
                $display("[TB] FAIL accept_timeout: got ready=%b, required 1 within 200 cycles", bus.dep_field_ready_o);
            end
            @(posedge clk);
            #1;
            bus.dep_field_valid_i = 1'b0;
            bus.dep_field_data_i  = rand128();
            bus.dep_field_last_i  = 1'b0;
        end
    endtask

    task automatic wait_drain();
        int w;
        w = 0;
        while ((exp_word.size() != 0 || exp_fin.size() != 0) && w < 300) begin
            @(negedge clk);
            w++;
        end
        repeat (3) @(negedge clk);
        tests_run++;
        if (exp_word.size() != 0 || exp_fin.size() != 0) begin
            tests_failed++;
            $display("[TB] FAIL drain: got %0d words and %0d finishes outstanding, required 0",
                     exp_word.size(), exp_fin.size());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        bus.dep_field_valid_i = 1'b0;
        bus.dep_field_last_i  = 1'b0;
        bus.dep_field_len_i   = '0;
        bus.dep_field_data_i  = '0;
        bus.dep_start_addr_i  = '0;
        bus.dep_data_ready_i  = 1'b1;
        resetn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        tests_run += 8;
        if (bus.dep_data_valid_o !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_valid: got %b, required 0", bus.dep_data_valid_o); end
        if (bus.dep_data_word_o !== '0) begin tests_failed++; $display("[TB] FAIL reset_word: got %h, required 0", bus.dep_data_word_o); end
        if (bus.dep_data_bits_o !== '0) begin tests_failed++; $display("[TB] FAIL reset_bits: got %0d, required 0", bus.dep_data_bits_o); end
        if (bus.dep_data_last_o !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_last: got %b, required 0", bus.dep_data_last_o); end
        if (bus.dep_finished_o !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_finished: got %b, required 0", bus.dep_finished_o); end
        if (bus.dep_finish_addr_o !== '0) begin tests_failed++; $display("[TB] FAIL reset_finish_addr: got %h, required 0", bus.dep_finish_addr_o); end
        if (bus.dep_field_ready_o !== 1'b1) begin tests_failed++; $display("[TB] FAIL reset_ready: got %b, required 1", bus.dep_field_ready_o); end
        if (bus.dep_hold_en_o !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_hold: got %b, required 0", bus.dep_hold_en_o); end
        resetn = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_full_word();
        int w0;
        int f0;
        w0 = n_words;
        f0 = n_fin;
        for (int i = 0; i < 4; i++) add_field(rand128(), 128, i == 3, 32'h100);
        commit_header();
        drive_fields(1'b0);
        wait_drain();
        tests_run += 6;
        if (n_words - w0 != 1) begin tests_failed++; $display("[TB] FAIL full_word_count: got %0d, required 1", n_words - w0); end
        if (obs_bits != 512) begin tests_failed++; $display("[TB] FAIL full_word_bits: got %0d, required 512", obs_bits); end
        if (obs_last !== 1'b1) begin tests_failed++; $display("[TB] FAIL full_word_last: got %b, required 1", obs_last); end
        if (n_fin - f0 != 1) begin tests_failed++; $display("[TB] FAIL full_word_pulses: got %0d, required 1", n_fin - f0); end
        if (obs_fin !== 32'h300) begin tests_failed++; $display("[TB] FAIL full_word_finish: got %h, required 00000300", obs_fin); end
        if (fin_cyc != hs_cyc + 1) begin tests_failed++; $display("[TB] FAIL finish_timing: got cycle %0d, required %0d", fin_cyc, hs_cyc + 1); end
    endtask

    task automatic test_ethernet();
        logic [PRS_OFFSET_W-1:0] s;
        int w0;
        s  = $urandom;
        w0 = n_words;
        add_field(rand128(), 48, 1'b0, s);
        add_field(rand128(), 48, 1'b0, s);
        add_field(rand128(), 16, 1'b1, s);
        commit_header();
        drive_fields(1'b0);
        wait_drain();
        tests_run += 3;
        if (n_words - w0 != 1) begin tests_failed++; $display("[TB] FAIL eth_count: got %0d, required 1", n_words - w0); end
        if (obs_bits != 112) begin tests_failed++; $display("[TB] FAIL eth_bits: got %0d, required 112", obs_bits); end
        if (obs_fin !== s + 32'd112) begin tests_failed++; $display("[TB] FAIL eth_finish: got %h, required %h", obs_fin, s + 32'd112); end
    endtask

    task automatic test_flush();
        logic [PRS_OFFSET_W-1:0] s;
        int w0;
        s  = $urandom;
        w0 = n_words;
        for (int i = 0; i < 5; i++) add_field(rand128(), 120, i == 4, s);
        commit_header();
        drive_fields(1'b0);
        tests_run += 2;
        if (bus.dep_field_ready_o !== 1'b0) begin tests_failed++; $display("[TB] FAIL flush_ready: got %b, required 0", bus.dep_field_ready_o); end
        if (bus.dep_hold_en_o !== 1'b1) begin tests_failed++; $display("[TB] FAIL flush_hold: got %b, required 1", bus.dep_hold_en_o); end
        wait_drain();
        tests_run += 4;
        if (n_words - w0 != 2) begin tests_failed++; $display("[TB] FAIL flush_count: got %0d, required 2", n_words - w0); end
        if (obs_bits != 88) begin tests_failed++; $display("[TB] FAIL flush_bits: got %0d, required 88", obs_bits); end
        if (obs_last !== 1'b1) begin tests_failed++; $display("[TB] FAIL flush_last: got %b, required 1", obs_last); end
        if (obs_fin !== s + 32'd600) begin tests_failed++; $display("[TB] FAIL flush_finish: got %h, required %h", obs_fin, s + 32'd600); end
    endtask

    task automatic test_backpressure();
        logic [DEP_FIELD_W-1:0] d;
        logic [PRS_DATA_W-1:0]  ew;
        d  = rand128();
        ew = '0;
        ew[PRS_DATA_W-1 -: 64] = d[63:0];
        bus.dep_data_ready_i = 1'b0;
        add_field(d, 64, 1'b1, $urandom);
        commit_header();
        drive_fields(1'b0);
        for (int i = 0; i < 5; i++) begin
            tests_run += 5;
            if (bus.dep_field_ready_o !== 1'b0) begin tests_failed++; $display("[TB] FAIL bp_ready: got %b, required 0", bus.dep_field_ready_o); end
            if (bus.dep_hold_en_o !== 1'b1) begin tests_failed++; $display("[TB] FAIL bp_hold: got %b, required 1", bus.dep_hold_en_o); end
            if (bus.dep_data_word_o !== ew) begin tests_failed++; $display("[TB] FAIL bp_word: got %h, required %h", bus.dep_data_word_o, ew); end
            if (bus.dep_data_bits_o !== BITS_W'(64)) begin tests_failed++; $display("[TB] FAIL bp_bits: got %0d, required 64", bus.dep_data_bits_o); end
            if (bus.dep_data_last_o !== 1'b1 || bus.dep_data_valid_o !== 1'b1) begin
                tests_failed++;
                $display("[TB] FAIL bp_valid_last: got valid=%b last=%b, required 1 1", bus.dep_data_valid_o, bus.dep_data_last_o);
            end
            if (i < 4) begin
                @(posedge clk);
                #1;
            end
        end
        bus.dep_data_ready_i = 1'b1;
        @(posedge clk);
        #1;
        tests_run += 2;
        if (bus.dep_data_valid_o !== 1'b0) begin tests_failed++; $display("[TB] FAIL bp_release_valid: got %b, required 0", bus.dep_data_valid_o); end
        if (bus.dep_field_ready_o !== 1'b1) begin tests_failed++; $display("[TB] FAIL bp_release_ready: got %b, required 1", bus.dep_field_ready_o); end
        wait_drain();
    endtask

    task automatic test_reset_mid();
        fld_t f;
        logic [PRS_OFFSET_W-1:0] s;
        for (int i = 0; i < 2; i++) begin
            f.data  = rand128();
            f.len   = 128;
            f.last  = 1'b0;
            f.start = 32'h40;
            fq.push_back(f);
        end
        drive_fields(1'b0);
        #3;
        resetn = 1'b0;
        #1;
        tests_run += 4;
        if (bus.dep_data_valid_o !== 1'b0) begin tests_failed++; $display("[TB] FAIL midreset_valid: got %b, required 0", bus.dep_data_valid_o); end
        if (bus.dep_finish_addr_o !== '0) begin tests_failed++; $display("[TB] FAIL midreset_finish_addr: got %h, required 0", bus.dep_finish_addr_o); end
        if (bus.dep_field_ready_o !== 1'b1) begin tests_failed++; $display("[TB] FAIL midreset_ready: got %b, required 1", bus.dep_field_ready_o); end
        if (bus.dep_hold_en_o !== 1'b0) begin tests_failed++; $display("[TB] FAIL midreset_hold: got %b, required 0", bus.dep_hold_en_o); end
        @(posedge clk);
        #1;
        resetn = 1'b1;
        s = $urandom;
        add_field(rand128(), 64, 1'b1, s);
        commit_header();
        drive_fields(1'b0);
        wait_drain();
        tests_run += 2;
        if (obs_bits != 64) begin tests_failed++; $display("[TB] FAIL midreset_bits: got %0d, required 64", obs_bits); end
        if (obs_fin !== s + 32'd64) begin tests_failed++; $display("[TB] FAIL midreset_finish: got %h, required %h", obs_fin, s + 32'd64); end
    endtask

    task automatic test_zero_len();
        logic [PRS_OFFSET_W-1:0] s;
        int w0;
        int f0;
        s  = $urandom;
        w0 = n_words;
        f0 = n_fin;
        add_field(rand128(), 0, 1'b1, s);
        commit_header();
        drive_fields(1'b0);
        wait_drain();
        tests_run += 3;
        if (n_words != w0) begin tests_failed++; $display("[TB] FAIL zero_words: got %0d, required 0", n_words - w0); end
        if (n_fin - f0 != 1) begin tests_failed++; $display("[TB] FAIL zero_pulses: got %0d, required 1", n_fin - f0); end
        if (obs_fin !== s) begin tests_failed++; $display("[TB] FAIL zero_finish: got %h, required %h", obs_fin, s); end
    endtask

    task automatic test_back_to_back();
        bit drv_done;
        int f0;
        int nf;
        f0 = n_fin;
        for (int h = 0; h < 25; h++) begin
            logic [PRS_OFFSET_W-1:0] s;
            s  = $urandom;
            nf = $urandom_range(1, 8);
            for (int i = 0; i < nf; i++) add_field(rand128(), $urandom_range(0, 140), i == nf - 1, s);
            commit_header();
        end
        drv_done = 1'b0;
        fork
            begin
                drive_fields(1'b1);
                drv_done = 1'b1;
            end
            begin
                while (!drv_done) begin
                    @(posedge clk);
                    #1;
                    bus.dep_data_ready_i = ($urandom_range(0, 3) != 0);
                end
                bus.dep_data_ready_i = 1'b1;
            end
        join
        wait_drain();
        tests_run++;
        if (n_fin - f0 != 25) begin tests_failed++; $display("[TB] FAIL b2b_pulses: got %0d, required 25", n_fin - f0); end
    endtask

    initial begin
        test_reset();
        test_full_word();
        test_ethernet();
        test_flush();
        test_backpressure();
        test_reset_mid();
        test_zero_len();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
